// File: rtl/bch_dec_chien_corr_if.sv
// Handshake bundle for the DEC BCH Chien-search corrector.
//   master : upstream/downstream side (drives in_valid_i, cw_i, synd_i, out_ready_i)
//   slave  : corrector side (drives in_ready_o, out_valid_o, cw_o, err_cnt_o, uncorr_o)
// P_CW_W : codeword width (data + 2*m parity)
// P_S_W  : remainder width (2*m)
interface bch_dec_chien_corr_if #(
    parameter int P_CW_W = 26,
    parameter int P_S_W  = 10
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [P_CW_W-1:0] cw_i;
    logic [P_S_W-1:0]  synd_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [P_CW_W-1:0] cw_o;
    logic [1:0]        err_cnt_o;
    logic              uncorr_o;

    modport master (
        output in_valid_i, cw_i, synd_i, out_ready_i,
        input  in_ready_o, out_valid_o, cw_o, err_cnt_o, uncorr_o
    );

    modport slave (
        input  in_valid_i, cw_i, synd_i, out_ready_i,
        output in_ready_o, out_valid_o, cw_o, err_cnt_o, uncorr_o
    );
endinterface

// File: rtl/bch_dec_chien_corr.sv
// Sequential double-error-correcting BCH corrector.
// Takes a received codeword and its remainder modulo g(x) = m1(x)*m3(x),
// evaluates S1 = r(alpha) and S3 = r(alpha^3) by Horner iteration, builds the
// S1-scaled error locator and runs a Chien search over the codeword positions.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : slave modport of bch_dec_chien_corr_if
//            in_valid_i/in_ready_o/cw_i/synd_i   input job handshake
//            out_valid_o/out_ready_i             result handshake
//            cw_o/err_cnt_o/uncorr_o             corrected word and status
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a new job
// ST_SYND  | Horner evaluation of S1/S3, one remainder bit per cycle
// ST_LOC   | build scaled locator, pick expected error count
// ST_CHIEN | test one codeword position per cycle, flip on root
// ST_DONE  | result presented until accepted
module bch_dec_chien_corr #(
    parameter int P_D_WIDTH = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    bch_dec_chien_corr_if.slave bus
);

    function automatic int fn_int_width(input int d);
        if (d + 10 <= 31)       return 31;
        else if (d + 12 <= 63)  return 63;
        else if (d + 14 <= 127) return 127;
        else                    return 255;
    endfunction

    function automatic int fn_gf_m(input int d);
        return $clog2(fn_int_width(d) + 1);
    endfunction

    function automatic int fn_calc_dat_ecc_width(input int d);
        return d + 2 * fn_gf_m(d);
    endfunction

    function automatic int fn_ecc_synd_width(input int d);
        return 2 * fn_gf_m(d);
    endfunction

    function automatic logic [8:0] fn_field_poly(input int m);
        case (m)
            5:       return 9'h025;
            6:       return 9'h043;
            7:       return 9'h089;
            default: return 9'h11D;
        endcase
    endfunction

    localparam int         LP_N     = fn_int_width(P_D_WIDTH);
    localparam int         LP_M     = $clog2(LP_N + 1);
    localparam int         LP_CW_W  = fn_calc_dat_ecc_width(P_D_WIDTH);
    localparam int         LP_S_W   = fn_ecc_synd_width(P_D_WIDTH);
    localparam int         LP_CNT_W = $clog2(LP_CW_W + 1);
    localparam logic [8:0] LP_POLY  = fn_field_poly(LP_M);

    typedef logic [LP_M-1:0] gf_t;

    function automatic gf_t gf_mul_a(input gf_t a);
        gf_t r;
        r = {a[LP_M-2:0], 1'b0};
        if (a[LP_M-1]) r = r ^ LP_POLY[LP_M-1:0];
        return r;
    endfunction

    // Division by alpha: make the value divisible by x by adding the field
    // polynomial (constant term is always 1), then shift down.
    function automatic gf_t gf_div_a(input gf_t a);
        logic [LP_M:0] t;
        t = {1'b0, a};
        if (a[0]) t = t ^ LP_POLY[LP_M:0];
        return t[LP_M:1];
    endfunction

    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t acc;
        gf_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < LP_M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_mul_a(sh);
        end
        return acc;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYND,
        ST_LOC,
        ST_CHIEN,
        ST_DONE
    } state_t;

    state_t               state,      state_nxt;
    logic [LP_CNT_W-1:0]  cnt,        cnt_nxt;
    logic [LP_S_W-1:0]    synd_reg,   synd_nxt;
    logic [LP_CW_W-1:0]   cw_work,    cw_work_nxt;
    logic [LP_CW_W-1:0]   cw_in,      cw_in_nxt;
    logic [LP_CW_W-1:0]   pos_mask,   pos_mask_nxt;
    gf_t                  s1,         s1_nxt;
    gf_t                  s3,         s3_nxt;
    gf_t                  t0,         t0_nxt;
    gf_t                  t1,         t1_nxt;
    gf_t                  t2,         t2_nxt;
    logic [1:0]           roots,      roots_nxt;
    logic [1:0]           exp_roots,  exp_roots_nxt;
    logic [LP_CW_W-1:0]   cw_out,     cw_out_nxt;
    logic [1:0]           err_out,    err_out_nxt;
    logic                 unc_out,    unc_out_nxt;

    gf_t        s1_horner;
    gf_t        s3_horner;
    gf_t        s1_sq;
    gf_t        s1_cu;
    logic       chien_hit;
    logic [1:0] roots_inc;

    assign s1_horner = gf_mul_a(s1) ^ gf_t'(synd_reg[LP_S_W-1]);
    assign s3_horner = gf_mul_a(gf_mul_a(gf_mul_a(s3))) ^ gf_t'(synd_reg[LP_S_W-1]);
    assign s1_sq     = gf_mul(s1, s1);
    assign s1_cu     = gf_mul(s1_sq, s1);
    assign chien_hit = ((t0 ^ t1 ^ t2) == '0);
    assign roots_inc = (roots == 2'd3) ? roots : roots + 2'd1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        synd_nxt      = synd_reg;
        cw_work_nxt   = cw_work;
        cw_in_nxt     = cw_in;
        pos_mask_nxt  = pos_mask;
        s1_nxt        = s1;
        s3_nxt        = s3;
        t0_nxt        = t0;
        t1_nxt        = t1;
        t2_nxt        = t2;
        roots_nxt     = roots;
        exp_roots_nxt = exp_roots;
        cw_out_nxt    = cw_out;
        err_out_nxt   = err_out;
        unc_out_nxt   = unc_out;

        case (state)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    cw_work_nxt = bus.cw_i;
                    cw_in_nxt   = bus.cw_i;
                    synd_nxt    = bus.synd_i;
                    s1_nxt      = '0;
                    s3_nxt      = '0;
                    cnt_nxt     = LP_CNT_W'(LP_S_W - 1);
                    state_nxt   = ST_SYND;
                end
            end

            ST_SYND: begin
                // Remainder is consumed MSB first so the Horner sums land on r(alpha), r(alpha^3).
                s1_nxt   = s1_horner;
                s3_nxt   = s3_horner;
                synd_nxt = {synd_reg[LP_S_W-2:0], 1'b0};
                cnt_nxt  = cnt - LP_CNT_W'(1);
                if (cnt == '0) begin
                    if (s1_horner == '0 && s3_horner == '0) begin
                        cw_out_nxt  = cw_in;
                        err_out_nxt = 2'd0;
                        unc_out_nxt = 1'b0;
                        state_nxt   = ST_DONE;
                    end else begin
                        state_nxt   = ST_LOC;
                    end
                end
            end

            ST_LOC: begin
                if (s1 == '0) begin
                    cw_out_nxt  = cw_in;
                    err_out_nxt = 2'd0;
                    unc_out_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    exp_roots_nxt = (s3 == s1_cu) ? 2'd1 : 2'd2;
                    t0_nxt        = s1;
                    t1_nxt        = s1_sq;
                    t2_nxt        = s3 ^ s1_cu;
                    roots_nxt     = 2'd0;
                    pos_mask_nxt  = {{(LP_CW_W-1){1'b0}}, 1'b1};
                    cnt_nxt       = LP_CNT_W'(LP_CW_W - 1);
                    state_nxt     = ST_CHIEN;
                end
            end

            ST_CHIEN: begin
                // t1/t2 track Lambda terms evaluated at alpha^-j for the current position j.
                if (chien_hit) begin
                    cw_work_nxt = cw_work ^ pos_mask;
                    roots_nxt   = roots_inc;
                end
                t1_nxt       = gf_div_a(t1);
                t2_nxt       = gf_div_a(gf_div_a(t2));
                pos_mask_nxt = {pos_mask[LP_CW_W-2:0], 1'b0};
                cnt_nxt      = cnt - LP_CNT_W'(1);
                if (cnt == '0) begin
                    // A root count short of the locator degree means a root sits in the
                    // shortened positions or the locator has no roots at all.
                    if (roots_nxt == exp_roots) begin
                        cw_out_nxt  = cw_work_nxt;
                        err_out_nxt = roots_nxt;
                        unc_out_nxt = 1'b0;
                    end else begin
                        cw_out_nxt  = cw_in;
                        err_out_nxt = 2'd0;
                        unc_out_nxt = 1'b1;
                    end
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.out_ready_i) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            synd_reg  <= '0;
            cw_work   <= '0;
            cw_in     <= '0;
            pos_mask  <= '0;
            s1        <= '0;
            s3        <= '0;
            t0        <= '0;
            t1        <= '0;
            t2        <= '0;
            roots     <= '0;
            exp_roots <= '0;
            cw_out    <= '0;
            err_out   <= '0;
            unc_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            synd_reg  <= synd_nxt;
            cw_work   <= cw_work_nxt;
            cw_in     <= cw_in_nxt;
            pos_mask  <= pos_mask_nxt;
            s1        <= s1_nxt;
            s3        <= s3_nxt;
            t0        <= t0_nxt;
            t1        <= t1_nxt;
            t2        <= t2_nxt;
            roots     <= roots_nxt;
            exp_roots <= exp_roots_nxt;
            cw_out    <= cw_out_nxt;
            err_out   <= err_out_nxt;
            unc_out   <= unc_out_nxt;
        end
    end

    assign bus.in_ready_o  = (state == ST_IDLE);
    assign bus.out_valid_o = (state == ST_DONE);
    assign bus.cw_o        = cw_out;
    assign bus.err_cnt_o   = err_out;
    assign bus.uncorr_o    = unc_out;

endmodule
